// File: rtl/ysyx_24110006_axi_rd_arbiter.sv
// ysyx_24110006_axi_rd_arbiter: round-robin 2:1 AXI4 read-channel arbiter (icache = m0, LSU = m1)
module ysyx_24110006_axi_rd_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              i_clock,
   input  logic              i_reset_n,
   input  logic [ADDR_W-1:0] i_m0_axi_araddr,
   input  logic              i_m0_axi_arvalid,
   output logic              o_m0_axi_arready,
   input  logic [7:0]        i_m0_axi_arlen,
   input  logic [2:0]        i_m0_axi_arsize,
   input  logic [1:0]        i_m0_axi_arburst,
   output logic [DATA_W-1:0] o_m0_axi_rdata,
   output logic              o_m0_axi_rvalid,
   input  logic              i_m0_axi_rready,
   output logic [1:0]        o_m0_axi_rresp,
   output logic              o_m0_axi_rlast,
   input  logic [ADDR_W-1:0] i_m1_axi_araddr,
   input  logic              i_m1_axi_arvalid,
   output logic              o_m1_axi_arready,
   input  logic [7:0]        i_m1_axi_arlen,
   input  logic [2:0]        i_m1_axi_arsize,
   input  logic [1:0]        i_m1_axi_arburst,
   output logic [DATA_W-1:0] o_m1_axi_rdata,
   output logic              o_m1_axi_rvalid,
   input  logic              i_m1_axi_rready,
   output logic [1:0]        o_m1_axi_rresp,
   output logic              o_m1_axi_rlast,
   output logic [ADDR_W-1:0] o_axi_araddr,
   output logic [7:0]        o_axi_arlen,
   output logic [2:0]        o_axi_arsize,
   output logic [1:0]        o_axi_arburst,
   output logic              o_axi_arvalid,
   input  logic              i_axi_arready,
   output logic [3:0]        o_axi_arid,
   input  logic [DATA_W-1:0] i_axi_rdata,
   input  logic [1:0]        i_axi_rresp,
   input  logic [3:0]        i_axi_rid,
   input  logic              i_axi_rlast,
   input  logic              i_axi_rvalid,
   output logic              o_axi_rready,
   output logic              o_grant,
   output logic              o_busy
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t     state;
   logic       grant;
   logic       last_grant;
   logic       busy;
   logic       in_addr;
   logic       in_data;
   logic       g_arvalid;
   logic       g_rready;
   logic       own0;
   logic       own1;
   logic [1:0] rresp_eff;

   assign in_addr   = state == ADDR;
   assign in_data   = state == DATA;
   assign g_arvalid = grant ? i_m1_axi_arvalid : i_m0_axi_arvalid;
   assign g_rready  = grant ? i_m1_axi_rready : i_m0_axi_rready;
   assign own0      = in_data && !grant;
   assign own1      = in_data && grant;
   assign rresp_eff = (i_axi_rid != {3'b000, grant}) ? 2'b10 : i_axi_rresp;

   assign o_axi_araddr  = grant ? i_m1_axi_araddr : i_m0_axi_araddr;
   assign o_axi_arlen   = grant ? i_m1_axi_arlen : i_m0_axi_arlen;
   assign o_axi_arsize  = grant ? i_m1_axi_arsize : i_m0_axi_arsize;
   assign o_axi_arburst = grant ? i_m1_axi_arburst : i_m0_axi_arburst;
   assign o_axi_arvalid = in_addr && g_arvalid;
   assign o_axi_arid    = {3'b000, grant};
   assign o_axi_rready  = in_data && g_rready;

   assign o_m0_axi_arready = in_addr && !grant && i_axi_arready;
   assign o_m1_axi_arready = in_addr && grant && i_axi_arready;

   assign o_m0_axi_rvalid = own0 && i_axi_rvalid;
   assign o_m0_axi_rlast  = own0 && i_axi_rlast;
   assign o_m0_axi_rdata  = own0 ? i_axi_rdata : '0;
   assign o_m0_axi_rresp  = own0 ? rresp_eff : 2'b00;
   assign o_m1_axi_rvalid = own1 && i_axi_rvalid;
   assign o_m1_axi_rlast  = own1 && i_axi_rlast;
   assign o_m1_axi_rdata  = own1 ? i_axi_rdata : '0;
   assign o_m1_axi_rresp  = own1 ? rresp_eff : 2'b00;

   assign o_grant = grant;
   assign o_busy  = busy;

   // Arbitration FSM: pick an owner in IDLE, hold it through AR handshake and the final R beat
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (i_m0_axi_arvalid || i_m1_axi_arvalid) begin
               grant <= (i_m0_axi_arvalid && i_m1_axi_arvalid) ? ~last_grant : i_m1_axi_arvalid;
               state <= ADDR;
               busy  <= 1'b1;
            end
            ADDR: if (!g_arvalid) begin
               state <= IDLE;
               busy  <= 1'b0;
            end else if (i_axi_arready) begin
               state <= DATA;
            end
            DATA: if (i_axi_rvalid && g_rready && i_axi_rlast) begin
               state      <= IDLE;
               busy       <= 1'b0;
               last_grant <= grant;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_24110006_axi_rd_arbiter.sv
// tb_ysyx_24110006_axi_rd_arbiter: directed and randomized checks against a transaction-level model
module tb_ysyx_24110006_axi_rd_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr[2];
   logic [7:0]  len[2];
   logic [2:0]  size[2];
   logic [1:0]  burst[2];
   logic        av[2];
   logic        rr[2];
   logic        arr_o[2];
   logic        rv_o[2];
   logic        rl_o[2];
   logic [31:0] rd_o[2];
   logic [1:0]  rs_o[2];
   logic        s_arready, s_rvalid, s_rlast;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic [3:0]  s_rid;
   logic [31:0] o_axi_araddr;
   logic [7:0]  o_axi_arlen;
   logic [2:0]  o_axi_arsize;
   logic [1:0]  o_axi_arburst;
   logic        o_axi_arvalid, o_axi_rready, o_grant, o_busy;
   logic [3:0]  o_axi_arid;

   int n_cmp = 0;
   int n_bad = 0;
   int owner;
   bit ar_done;
   bit last;
   int beats_left;

   always #5 clk = ~clk;

   ysyx_24110006_axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .i_clock(clk), .i_reset_n(rst_n),
      .i_m0_axi_araddr(addr[0]), .i_m0_axi_arvalid(av[0]), .o_m0_axi_arready(arr_o[0]),
      .i_m0_axi_arlen(len[0]), .i_m0_axi_arsize(size[0]), .i_m0_axi_arburst(burst[0]),
      .o_m0_axi_rdata(rd_o[0]), .o_m0_axi_rvalid(rv_o[0]), .i_m0_axi_rready(rr[0]),
      .o_m0_axi_rresp(rs_o[0]), .o_m0_axi_rlast(rl_o[0]),
      .i_m1_axi_araddr(addr[1]), .i_m1_axi_arvalid(av[1]), .o_m1_axi_arready(arr_o[1]),
      .i_m1_axi_arlen(len[1]), .i_m1_axi_arsize(size[1]), .i_m1_axi_arburst(burst[1]),
      .o_m1_axi_rdata(rd_o[1]), .o_m1_axi_rvalid(rv_o[1]), .i_m1_axi_rready(rr[1]),
      .o_m1_axi_rresp(rs_o[1]), .o_m1_axi_rlast(rl_o[1]),
      .o_axi_araddr(o_axi_araddr), .o_axi_arlen(o_axi_arlen), .o_axi_arsize(o_axi_arsize),
      .o_axi_arburst(o_axi_arburst), .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(s_arready),
      .o_axi_arid(o_axi_arid), .i_axi_rdata(s_rdata), .i_axi_rresp(s_rresp), .i_axi_rid(s_rid),
      .i_axi_rlast(s_rlast), .i_axi_rvalid(s_rvalid), .o_axi_rready(o_axi_rready),
      .o_grant(o_grant), .o_busy(o_busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic quiet(input string tag);
      check({tag, "_busy"}, o_busy, 0);
      check({tag, "_arvalid"}, o_axi_arvalid, 0);
      check({tag, "_rready"}, o_axi_rready, 0);
      check({tag, "_arready"}, {arr_o[1], arr_o[0]}, 0);
      check({tag, "_rvalid"}, {rv_o[1], rv_o[0]}, 0);
   endtask

   // One clock: check DUT outputs against the model, then advance the model at the edge
   task automatic cycle();
      int clr;
      clr = -1;
      #1;
      check("busy", o_busy, owner >= 0);
      if (owner < 0) begin
         check("idle_arvalid", o_axi_arvalid, 0);
         check("idle_arready", {arr_o[1], arr_o[0]}, 0);
         check("idle_rready", o_axi_rready, 0);
         check("idle_rvalid", {rv_o[1], rv_o[0]}, 0);
         check("idle_rlast", {rl_o[1], rl_o[0]}, 0);
      end else if (!ar_done) begin
         check("ar_grant", o_grant, owner);
         check("ar_valid", o_axi_arvalid, av[owner]);
         check("ar_addr", o_axi_araddr, addr[owner]);
         check("ar_len", o_axi_arlen, len[owner]);
         check("ar_size", o_axi_arsize, size[owner]);
         check("ar_burst", o_axi_arburst, burst[owner]);
         check("ar_id", o_axi_arid, owner);
         check("ar_ready_own", arr_o[owner], s_arready);
         check("ar_ready_oth", arr_o[1-owner], 0);
         check("ar_rready", o_axi_rready, 0);
         check("ar_rvalid", {rv_o[1], rv_o[0]}, 0);
      end else begin
         check("r_grant", o_grant, owner);
         check("r_rready", o_axi_rready, rr[owner]);
         check("r_arvalid", o_axi_arvalid, 0);
         check("r_rvalid_own", rv_o[owner], s_rvalid);
         check("r_rvalid_oth", rv_o[1-owner], 0);
         check("r_rlast_oth", rl_o[1-owner], 0);
         check("r_rdata_oth", rd_o[1-owner], 0);
         if (s_rvalid) begin
            check("r_rdata_own", rd_o[owner], s_rdata);
            check("r_rlast_own", rl_o[owner], s_rlast);
            check("r_rresp_own", rs_o[owner], (s_rid == 4'(owner)) ? s_rresp : 2'b10);
         end
      end
      @(posedge clk);
      if (owner < 0) begin
         if (av[0] || av[1]) begin
            owner   = (av[0] && av[1]) ? (last ? 0 : 1) : (av[1] ? 1 : 0);
            ar_done = 0;
         end
      end else if (!ar_done) begin
         if (!av[owner]) owner = -1;
         else if (s_arready) begin
            ar_done    = 1;
            beats_left = len[owner];
            clr        = owner;
         end
      end else if (s_rvalid && rr[owner]) begin
         if (s_rlast) begin
            last  = owner[0];
            owner = -1;
         end else beats_left--;
      end
      #1;
      if (clr >= 0) av[clr] = 1'b0;
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1 quiet("arst");
      owner = -1;
      ar_done = 0;
      last = 1;
      av[0] = 0;
      av[1] = 0;
      s_rvalid = 0;
      s_rlast = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && owner >= 0; i++) begin
         s_arready = 1;
         rr[0] = 1;
         rr[1] = 1;
         s_rvalid = ar_done;
         s_rid = 4'(owner);
         s_rresp = 2'b00;
         s_rdata = $urandom;
         s_rlast = ar_done && beats_left <= 0;
         cycle();
      end
      s_rvalid = 0;
      s_rlast = 0;
   endtask

   task automatic request(input int m, input logic [31:0] a, input logic [7:0] l);
      addr[m] = a;
      len[m] = l;
      size[m] = 3'($urandom);
      burst[m] = 2'($urandom);
      av[m] = 1;
   endtask

   task automatic rand_inputs();
      for (int m = 0; m < 2; m++) begin
         if (!av[m] && $urandom_range(0, 3) == 0) request(m, $urandom, 8'($urandom_range(0, 3)));
         rr[m] = $urandom_range(0, 3) != 0;
      end
      s_arready = 1'($urandom_range(0, 1));
      s_rdata = $urandom;
      s_rresp = 2'($urandom);
      if (owner >= 0 && ar_done) begin
         s_rvalid = $urandom_range(0, 2) != 0;
         s_rlast = s_rvalid ? (beats_left <= 0) : 1'($urandom_range(0, 1));
         s_rid = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'(owner);
      end else begin
         s_rvalid = 0;
         s_rlast = 1'($urandom_range(0, 1));
         s_rid = 4'($urandom);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      for (int m = 0; m < 2; m++) begin
         addr[m] = 0; len[m] = 0; size[m] = 0; burst[m] = 0; av[m] = 0; rr[m] = 0;
      end
      s_arready = 0; s_rvalid = 0; s_rlast = 0; s_rdata = 0; s_rresp = 0; s_rid = 0;
      owner = -1; ar_done = 0; last = 1; beats_left = 0;
      #3 quiet("rst");
      @(posedge clk);
      #1 rst_n = 1'b1;

      request(0, 32'h8000_0008, 8'd1);
      cycle();
      #1;
      check("t1_arvalid", o_axi_arvalid, 1);
      check("t1_arid", o_axi_arid, 0);
      s_arready = 1;
      cycle();
      s_arready = 0; rr[0] = 1; rr[1] = 1; s_rvalid = 1; s_rid = 0; s_rresp = 0; s_rdata = 32'h11;
      cycle();
      s_rdata = 32'h22; s_rlast = 1;
      #1;
      check("t1_rdata2", rd_o[0], 32'h22);
      check("t1_rlast2", rl_o[0], 1);
      check("t1_m1_rvalid", rv_o[1], 0);
      cycle();
      s_rvalid = 0; s_rlast = 0;
      cycle();

      do_reset();
      request(0, 32'h100, 8'd0);
      request(1, 32'h200, 8'd0);
      cycle();
      #1 check("t2_first", o_grant, 0);
      drain();
      cycle();
      #1;
      check("t2_second", o_grant, 1);
      check("t2_arid", o_axi_arid, 1);
      drain();
      request(0, 32'h300, 8'd1);
      request(1, 32'h400, 8'd1);
      cycle();
      #1 check("t2_repeat", o_grant, 0);
      drain();
      cycle();
      drain();

      request(1, 32'h1234_5678, 8'd2);
      s_arready = 0;
      cycle();
      repeat (5) cycle();
      #1;
      check("t3_stall_addr", o_axi_araddr, 32'h1234_5678);
      check("t3_stall_valid", o_axi_arvalid, 1);
      s_arready = 1;
      cycle();
      s_arready = 0; s_rvalid = 1; s_rid = 0; s_rresp = 0; s_rdata = 32'hdead_beef; s_rlast = 0; rr[1] = 0;
      cycle();
      cycle();
      rr[1] = 1;
      #1;
      check("t3_slverr", rs_o[1], 2'b10);
      check("t3_rdata", rd_o[1], 32'hdead_beef);
      cycle();
      s_rid = 1;
      cycle();
      s_rlast = 1;
      cycle();
      s_rvalid = 0; s_rlast = 0;

      request(0, 32'h500, 8'd0);
      cycle();
      drain();
      request(1, 32'h600, 8'd0);
      cycle();
      av[1] = 0;
      cycle();
      #1 check("t4_abort_busy", o_busy, 0);
      request(0, 32'h700, 8'd0);
      request(1, 32'h800, 8'd0);
      cycle();
      #1 check("t4_tie", o_grant, 1);
      drain();
      cycle();
      drain();

      request(0, 32'h900, 8'd3);
      s_arready = 1;
      cycle();
      cycle();
      s_rvalid = 1; rr[0] = 1; s_rid = 0; s_rlast = 0; s_rdata = 32'haa;
      cycle();
      s_rvalid = 1;
      do_reset();
      request(0, 32'ha00, 8'd0);
      request(1, 32'hb00, 8'd0);
      cycle();
      #1 check("t5_tie", o_grant, 0);
      drain();
      cycle();
      drain();

      repeat (3000) begin
         rand_inputs();
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ysyx_24110006_axi_rd_arbiter.md
# ysyx_24110006_axi_rd_arbiter

Two-to-one AXI4 read-channel arbiter that shares the single core-side AXI read port between the instruction cache (master 0) and the LSU (master 1). It grants one read transaction (AR handshake through final R beat) at a time, uses round-robin priority on contention, and routes R beats back to the owning master only. It sits between both requesters and the core's AXI master interface; write channels bypass it.

## Interface
- Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: read data width.
- Ports:
- `i_clock`  in  1  core clock; single clock domain.
- `i_reset_n`  in  1  reset; asynchronous assert, active-low.
- `i_mN_axi_araddr`  in  ADDR_W  master N (N=0,1) read address.
- `i_mN_axi_arvalid`  in  1  master N address valid.
- `o_mN_axi_arready`  out  1  master N address ready.
- `i_mN_axi_arlen`  in  8  burst length.
- `i_mN_axi_arsize`  in  3  beat size.
- `i_mN_axi_arburst`  in  2  burst type.
- `o_mN_axi_rdata`  out  DATA_W  routed read data.
- `o_mN_axi_rvalid`  out  1  routed data valid.
- `i_mN_axi_rready`  in  1  master N data ready.
- `o_mN_axi_rresp`  out  2  routed response.
- `o_mN_axi_rlast`  out  1  routed last beat.
- `o_axi_araddr` / `o_axi_arlen` / `o_axi_arsize` / `o_axi_arburst`  out  ADDR_W/8/3/2  granted master's AR fields.
- `o_axi_arvalid`  out  1  downstream address valid.
- `i_axi_arready`  in  1  downstream address ready.
- `o_axi_arid`  out  4  `{3'b0, grant}`.
- `i_axi_rdata` / `i_axi_rresp` / `i_axi_rid` / `i_axi_rlast`  in  DATA_W/2/4/1  downstream R fields.
- `i_axi_rvalid`  in  1  downstream data valid.
- `o_axi_rready`  out  1  owner's rready during the R phase, else 0.
- `o_grant`  out  1  current owner index; meaningful in the AR and R phases.
- `o_busy`  out  1  high in the AR and R phases.

## Operation
- FSM with states IDLE, ADDR and DATA. Registers: `state`, `grant`, and `last_grant`.
- **IDLE:**
  - If exactly one `i_mN_axi_arvalid` is high, set `grant`=N and go to ADDR.
  - If both are high, set `grant`=`!last_grant` and go to ADDR.
  - If neither is high, stay in IDLE.
  - All `o_mN_axi_arready`=0, `o_axi_arvalid`=0 and `o_axi_rready`=0.
- **ADDR:**
  - `o_axi_arvalid` equals the granted master's arvalid, and the AR fields mux from the granted master.
  - `o_mN_axi_arready` equals `i_axi_arready` for the granted master and 0 for the other.
  - On `o_axi_arvalid && i_axi_arready`, go to DATA.
  - If the granted arvalid drops before the handshake (protocol violation), return to IDLE and leave `last_grant` unchanged.
- **DATA:**
  - The owner's `o_mN_axi_rvalid`, `rdata`, `rresp` and `rlast` follow the downstream R channel. The other master sees `rvalid`=0, `rlast`=0 and `rdata`=0.
  - `o_axi_rready` equals the owner's `i_mN_axi_rready`.
  - A beat transfers on `i_axi_rvalid && o_axi_rready`.
  - On a beat with `i_axi_rlast`=1, go to IDLE and set `last_grant`=`grant`.
  - `i_axi_rlast` without `i_axi_rvalid` is ignored.
- **ID check:** on any DATA beat where `i_axi_rid[0]!=grant` or `i_axi_rid[3:1]!=0`, `o_mN_axi_rresp` is forced to 2'b10 (SLVERR). Data still passes.
- Requests from the non-owner stay pending (its arready is 0) until the FSM returns to IDLE.

## Timing
- **Reset** (async, `i_reset_n`=0):
  - State goes to IDLE, `grant`=0 and `last_grant`=1, so master 0 wins the first tie.
  - All valid and ready outputs are 0, and `o_busy`=0.
  - Reset mid-burst abandons the transaction; the downstream slave is reset by the same net.
- **Arbitration latency:**
  - arvalid seen in IDLE at cycle T gives `o_axi_arvalid`=1 at cycle T+1.
  - The earliest AR handshake is at T+1, with DATA from T+2.
- R path is combinational pass-through; no added latency on data beats.
- **Back-to-back:**
  - The final beat at cycle T gives IDLE at T+1.
  - A pending request is then granted at T+1, with ADDR at T+2.
  - This leaves a minimum bubble of 2 cycles between bursts.
- `o_busy` = (state!=IDLE), registered.
- Only one outstanding transaction exists at any time; no ID reordering.

## Test plan
- **Single request:** m0 requests araddr 0x8000_0008, arlen 1.
  - `o_axi_arvalid` must rise 1 cycle later with `o_axi_arid`=0.
  - Two beats 0x11, 0x22 must reach m0 only, with `rlast` on the second.
  - m1 must see `rvalid`=0 throughout.
- **Simultaneous after reset:** m0 and m1 request in the same cycle.
  - m0 is granted first.
  - After m0's rlast, m1 is granted 2 cycles later with `o_axi_arid`=1.
  - On a repeated tie, m1 must win next only if m0 was the last grantee.
- **Backpressure:**
  - Holding `i_axi_arready`=0 for 5 cycles keeps the FSM in ADDR with fields stable.
  - Owner `rready`=0 mid-burst must drive `o_axi_rready`=0 with no beat lost.
- **ID mismatch:** granted m1, slave returns `rid`=0 with `rresp` OKAY → m1 sees `rresp`=2'b10.
- **Async reset mid-DATA:** dropping `i_reset_n` between beats clears all valids and `o_busy` within the same cycle. After release, the next tie grants m0.
